// File: rtl/divider_pipe.sv
// Pipelined restoring divider: one input stage (sign strip, flag detect),
// N division stages producing one quotient bit each (MSB first), and one
// output stage applying the sign fix-up. Latency is N+2 enabled cycles.
module divider_pipe #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             in_valid,
  input  logic [N-1:0]     dividend,
  input  logic [M-1:0]     divisor,
  input  logic             sgn,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  output logic [N-1:0]     quotient,
  output logic [M-1:0]     remainder,
  output logic             div_zero,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  // Stage k (0..N): k=0 is the input stage, k>0 holds k quotient bits.
  logic             v   [0:N];
  logic             nq  [0:N];   // quotient must be negated
  logic             nr  [0:N];   // remainder must be negated
  logic             dz  [0:N];
  logic             ov  [0:N];
  logic [TAG_W-1:0] tg  [0:N];
  logic [M-1:0]     rem [0:N];
  logic [N-1:0]     quo [0:N];
  // Remaining dividend bits and divisor magnitude are not needed after stage N-1.
  logic [N-1:0]     dvd [0:N-1];
  logic [M:0]       dvs [0:N-1];

  // Next-state of each division stage, indexed by the stage it feeds (k+1 -> [k]).
  logic [M-1:0]     rem_n [0:N-1];
  logic [N-1:0]     quo_n [0:N-1];

  // Input-stage decode
  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;
  logic             ovf_det;
  logic [M:0]       dvs_ext;
  logic [N-1:0]     dvd_mag;
  logic [M:0]       dvs_mag;

  // Magnitudes and flags; a zero divisor runs the raw dividend through unsigned
  // so the quotient saturates to all ones and the remainder is dividend[M-1:0].
  always_comb begin
    dvs_zero = (divisor == '0);
    dvd_neg  = sgn & dividend[N-1] & ~dvs_zero;
    dvs_neg  = sgn & divisor[M-1];
    dvs_ext  = {dvs_neg, divisor};
    dvs_mag  = dvs_neg ? -dvs_ext : dvs_ext;
    dvd_mag  = dvd_neg ? -dividend : dividend;
    ovf_det  = sgn & (dividend == MOST_NEG) & (&divisor);
  end

  // One restoring step per stage on an M+1-bit partial remainder
  always_comb begin
    logic [M:0] sh;
    logic [M:0] diff;
    for (int unsigned k = 0; k < N; k++) begin
      sh   = {rem[k], dvd[k][N-1]};
      diff = sh - dvs[k];
      if (sh >= dvs[k]) begin
        rem_n[k] = diff[M-1:0];
        quo_n[k] = {quo[k][N-2:0], 1'b1};
      end else begin
        rem_n[k] = sh[M-1:0];
        quo_n[k] = {quo[k][N-2:0], 1'b0};
      end
    end
  end

  // Pipeline registers: all stages advance together on en
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k <= N; k++) begin
        v[k]   <= 1'b0;
        nq[k]  <= 1'b0;
        nr[k]  <= 1'b0;
        dz[k]  <= 1'b0;
        ov[k]  <= 1'b0;
        tg[k]  <= '0;
        rem[k] <= '0;
        quo[k] <= '0;
      end
      for (int unsigned k = 0; k < N; k++) begin
        dvd[k] <= '0;
        dvs[k] <= '0;
      end
    end else if (en) begin
      v[0]   <= in_valid;
      nq[0]  <= dvd_neg ^ dvs_neg;
      nr[0]  <= dvd_neg;
      dz[0]  <= dvs_zero;
      ov[0]  <= ovf_det;
      tg[0]  <= tag_in;
      rem[0] <= '0;
      quo[0] <= '0;
      dvd[0] <= dvd_mag;
      dvs[0] <= dvs_mag;
      for (int unsigned k = 0; k < N; k++) begin
        v[k+1]   <= v[k];
        nq[k+1]  <= nq[k];
        nr[k+1]  <= nr[k];
        dz[k+1]  <= dz[k];
        ov[k+1]  <= ov[k];
        tg[k+1]  <= tg[k];
        rem[k+1] <= rem_n[k];
        quo[k+1] <= quo_n[k];
        if (k + 1 < N) begin
          dvd[k+1] <= dvd[k] << 1;
          dvs[k+1] <= dvs[k];
        end
      end
    end
  end

  // Output stage: sign fix-up and registered results
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      tag_out   <= '0;
    end else if (en) begin
      out_valid <= v[N];
      quotient  <= nq[N] ? -quo[N] : quo[N];
      remainder <= nr[N] ? -rem[N] : rem[N];
      div_zero  <= dz[N];
      ovf       <= ov[N];
      tag_out   <= tg[N];
    end
  end

endmodule
